// File: rtl/fft_input_packer_pkg.sv
// Shared definitions for the FFT input packer: bank-state encoding and
// elaboration-time helpers for frame geometry.
package fft_input_packer_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  localparam int unsigned MIN_N_POINT = 4;

  // Radix-4 framing needs a whole number of 4-sample groups.
  function automatic bit n_point_legal(input int unsigned n);
    return (n >= MIN_N_POINT) && ((n % 4) == 0);
  endfunction

  function automatic int unsigned slot_offset(input int unsigned data_width,
                                              input int unsigned k);
    return data_width * k;
  endfunction

endpackage

// File: rtl/fft_input_packer_frame_bank.sv
// One frame of N_POINT complex samples; written one slot at a time,
// read out as a flat packed vector with sample k at DATA_WIDTH*k.
module fft_frame_bank
  import fft_input_packer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned N_POINT    = 4,
  parameter int unsigned IDX_W      = 2
) (
  input  logic                          sys_clk_i,
  input  logic                          wr_en,
  input  logic [IDX_W-1:0]              wr_idx,
  input  logic [DATA_WIDTH-1:0]         wr_real,
  input  logic [DATA_WIDTH-1:0]         wr_imag,
  output logic [DATA_WIDTH*N_POINT-1:0] rd_real,
  output logic [DATA_WIDTH*N_POINT-1:0] rd_imag
);

  logic [DATA_WIDTH-1:0] real_mem [N_POINT];
  logic [DATA_WIDTH-1:0] imag_mem [N_POINT];

  // Data storage carries no reset; validity is tracked by the bank state.
  always_ff @(posedge sys_clk_i) begin
    if (wr_en) begin
      real_mem[wr_idx] <= wr_real;
      imag_mem[wr_idx] <= wr_imag;
    end
  end

  for (genvar k = 0; k < N_POINT; k++) begin : g_slot
    assign rd_real[slot_offset(DATA_WIDTH, k) +: DATA_WIDTH] = real_mem[k];
    assign rd_imag[slot_offset(DATA_WIDTH, k) +: DATA_WIDTH] = imag_mem[k];
  end

endmodule

// File: rtl/fft_input_packer.sv
// Ping-pong packer: collects N_POINT streamed complex samples per frame and
// presents each completed frame as one wide word to the butterfly stage.
module fft_input_packer
  import fft_input_packer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned N_POINT    = 4
) (
  input  logic                          sys_clk_i,
  input  logic                          rst_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [DATA_WIDTH-1:0]         s_real_i,
  input  logic [DATA_WIDTH-1:0]         s_imag_i,
  input  logic                          s_last_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [DATA_WIDTH*N_POINT-1:0] xn_real_o,
  output logic [DATA_WIDTH*N_POINT-1:0] xn_imag_o,
  output logic                          frame_err_o
);

  localparam int unsigned      IDX_W    = $clog2(N_POINT);
  localparam int unsigned      FRAME_W  = DATA_WIDTH * N_POINT;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINT - 1);

  if (!n_point_legal(N_POINT)) begin : g_bad_n_point
    $error("fft_input_packer: N_POINT must be a multiple of 4 and at least 4");
  end

  bank_state_e      bank_st_q [2];
  bank_state_e      bank_st_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             s_ready_q, s_ready_d;
  logic             frame_err_q, frame_err_d;
  logic             in_fire, out_fire, last_slot;
  logic [1:0]       bank_we;
  logic [FRAME_W-1:0] bank_real [2];
  logic [FRAME_W-1:0] bank_imag [2];

  assign in_fire     = s_valid_i && s_ready_q;
  assign out_fire    = m_valid_o && m_ready_i;
  assign last_slot   = (wr_idx_q == LAST_IDX);

  assign s_ready_o   = s_ready_q;
  assign m_valid_o   = (bank_st_q[rd_ptr_q] == BANK_FULL);
  assign frame_err_o = frame_err_q;
  assign xn_real_o   = bank_real[rd_ptr_q];
  assign xn_imag_o   = bank_imag[rd_ptr_q];

  always_comb begin
    bank_st_d   = bank_st_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_idx_d    = wr_idx_q;
    frame_err_d = 1'b0;

    // A drain and a fill never touch the same bank: the write bank is not
    // FULL while accepting, and only a FULL bank can drain.
    if (out_fire) begin
      bank_st_d[rd_ptr_q] = BANK_EMPTY;
      rd_ptr_d            = ~rd_ptr_q;
    end

    if (in_fire) begin
      if (last_slot) begin
        bank_st_d[wr_ptr_q] = BANK_FULL;
        wr_idx_d            = '0;
        wr_ptr_d            = ~wr_ptr_q;
        frame_err_d         = ~s_last_i;
      end else if (s_last_i) begin
        bank_st_d[wr_ptr_q] = BANK_EMPTY;
        wr_idx_d            = '0;
        frame_err_d         = 1'b1;
      end else begin
        bank_st_d[wr_ptr_q] = BANK_FILLING;
        wr_idx_d            = wr_idx_q + 1'b1;
      end
    end

    // Registered ready looks at next-cycle bank state so a same-cycle
    // drain reopens the input one cycle later with no path from m_ready_i.
    s_ready_d = (bank_st_d[wr_ptr_d] != BANK_FULL);
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      bank_st_q[0] <= BANK_EMPTY;
      bank_st_q[1] <= BANK_EMPTY;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      wr_idx_q     <= '0;
      s_ready_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      bank_st_q    <= bank_st_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_idx_q     <= wr_idx_d;
      s_ready_q    <= s_ready_d;
      frame_err_q  <= frame_err_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b] = in_fire && (wr_ptr_q == 1'(b));

    fft_frame_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .N_POINT    (N_POINT),
      .IDX_W      (IDX_W)
    ) u_bank (
      .sys_clk_i  (sys_clk_i),
      .wr_en      (bank_we[b]),
      .wr_idx     (wr_idx_q),
      .wr_real    (s_real_i),
      .wr_imag    (s_imag_i),
      .rd_real    (bank_real[b]),
      .rd_imag    (bank_imag[b])
    );
  end

endmodule

// File: tb/tb_fft_input_packer.sv
// Directed bench for fft_input_packer (DATA_WIDTH=8, N_POINT=4).
module tb_fft_input_packer;

  localparam int unsigned DW = 8;
  localparam int unsigned NP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, s_last, m_valid, m_ready, frame_err;
  logic [DW-1:0] s_real, s_imag;
  logic [31:0]   xn_real, xn_imag;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  fft_input_packer #(
    .DATA_WIDTH (DW),
    .N_POINT    (NP)
  ) dut (
    .sys_clk_i   (clk),
    .rst_i       (rst),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .s_real_i    (s_real),
    .s_imag_i    (s_imag),
    .s_last_i    (s_last),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .xn_real_o   (xn_real),
    .xn_imag_o   (xn_imag),
    .frame_err_o (frame_err)
  );

  // Inputs are driven for the coming edge; expectations describe the
  // outputs visible during the same cycle, before that edge.
  typedef struct {
    logic        sv;
    logic [7:0]  re;
    logic [7:0]  im;
    logic        sl;
    logic        mr;
    logic        e_sr;
    logic        e_mv;
    logic        e_fe;
    logic        cd;
    logic [31:0] e_re;
    logic [31:0] e_im;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic sv, logic [7:0] re, logic [7:0] im, logic sl,
                             logic mr, logic e_sr, logic e_mv, logic e_fe,
                             logic cd, logic [31:0] e_re, logic [31:0] e_im);
    vec_t r;
    r.sv = sv; r.re = re; r.im = im; r.sl = sl; r.mr = mr;
    r.e_sr = e_sr; r.e_mv = e_mv; r.e_fe = e_fe;
    r.cd = cd; r.e_re = e_re; r.e_im = e_im;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic sv, input logic [7:0] re, input logic [7:0] im,
                       input logic sl, input logic mr);
    s_valid = sv; s_real = re; s_imag = im; s_last = sl; m_ready = mr;
  endtask

  initial begin
    int unsigned frames;
    logic [31:0] exp_re, exp_im;

    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;

    // Idle row helper values
    // REQ: basic frame, bit-exact packing of signed samples
    tbl.push_back(v(1, 8'h01, 8'hFF, 0, 1, 1, 0, 0, 0, '0, '0));
    tbl.push_back(v(1, 8'h02, 8'hFE, 0, 1, 1, 0, 0, 0, '0, '0));
    tbl.push_back(v(1, 8'h03, 8'hFD, 0, 1, 1, 0, 0, 0, '0, '0));
    tbl.push_back(v(1, 8'h04, 8'hFC, 1, 1, 1, 0, 0, 0, '0, '0));
    tbl.push_back(v(0, 8'h00, 8'h00, 0, 1, 1, 1, 0, 1, 32'h04030201, 32'hFCFDFEFF));
    tbl.push_back(v(0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 0, '0, '0));
    // Early s_last on the 2nd sample: discard and flag, then a clean frame
    tbl.push_back(v(1, 8'h05, 8'hFB, 0, 1, 1, 0, 0, 0, '0, '0));
    tbl.push_back(v(1, 8'h06, 8'hFA, 1, 1, 1, 0, 0, 0, '0, '0));
    tbl.push_back(v(0, 8'h00, 8'h00, 0, 1, 1, 0, 1, 0, '0, '0));
    tbl.push_back(v(0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 0, '0, '0));
    tbl.push_back(v(1, 8'h07, 8'hF9, 0, 1, 1, 0, 0, 0, '0, '0));
    tbl.push_back(v(1, 8'h08, 8'hF8, 0, 1, 1, 0, 0, 0, '0, '0));
    tbl.push_back(v(1, 8'h09, 8'hF7, 0, 1, 1, 0, 0, 0, '0, '0));
    tbl.push_back(v(1, 8'h0A, 8'hF6, 1, 1, 1, 0, 0, 0, '0, '0));
    tbl.push_back(v(0, 8'h00, 8'h00, 0, 1, 1, 1, 0, 1, 32'h0A090807, 32'hF6F7F8F9));
    tbl.push_back(v(0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 0, '0, '0));
    // Missing s_last: frame still commits, error pulses, output held while stalled
    tbl.push_back(v(1, 8'h11, 8'h80, 0, 0, 1, 0, 0, 0, '0, '0));
    tbl.push_back(v(1, 8'h22, 8'h7F, 0, 0, 1, 0, 0, 0, '0, '0));
    tbl.push_back(v(1, 8'h33, 8'h00, 0, 0, 1, 0, 0, 0, '0, '0));
    tbl.push_back(v(1, 8'h44, 8'hFF, 0, 0, 1, 0, 0, 0, '0, '0));
    tbl.push_back(v(0, 8'h00, 8'h00, 0, 0, 1, 1, 1, 1, 32'h44332211, 32'hFF007F80));
    tbl.push_back(v(0, 8'h00, 8'h00, 0, 0, 1, 1, 0, 1, 32'h44332211, 32'hFF007F80));
    tbl.push_back(v(0, 8'h00, 8'h00, 0, 1, 1, 1, 0, 1, 32'h44332211, 32'hFF007F80));
    tbl.push_back(v(0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 0, '0, '0));
    // Eight samples with downstream stalled: both banks fill, input backpressures
    tbl.push_back(v(1, 8'h10, 8'hA0, 0, 0, 1, 0, 0, 0, '0, '0));
    tbl.push_back(v(1, 8'h11, 8'hA1, 0, 0, 1, 0, 0, 0, '0, '0));
    tbl.push_back(v(1, 8'h12, 8'hA2, 0, 0, 1, 0, 0, 0, '0, '0));
    tbl.push_back(v(1, 8'h13, 8'hA3, 1, 0, 1, 0, 0, 0, '0, '0));
    tbl.push_back(v(1, 8'h14, 8'hA4, 0, 0, 1, 1, 0, 1, 32'h13121110, 32'hA3A2A1A0));
    tbl.push_back(v(1, 8'h15, 8'hA5, 0, 0, 1, 1, 0, 1, 32'h13121110, 32'hA3A2A1A0));
    tbl.push_back(v(1, 8'h16, 8'hA6, 0, 0, 1, 1, 0, 1, 32'h13121110, 32'hA3A2A1A0));
    tbl.push_back(v(1, 8'h17, 8'hA7, 1, 0, 1, 1, 0, 1, 32'h13121110, 32'hA3A2A1A0));
    // Offered while not ready: must be ignored
    tbl.push_back(v(1, 8'hEE, 8'hEE, 0, 0, 0, 1, 0, 1, 32'h13121110, 32'hA3A2A1A0));
    tbl.push_back(v(0, 8'h00, 8'h00, 0, 1, 0, 1, 0, 1, 32'h13121110, 32'hA3A2A1A0));
    tbl.push_back(v(0, 8'h00, 8'h00, 0, 0, 1, 1, 0, 1, 32'h17161514, 32'hA7A6A5A4));
    tbl.push_back(v(0, 8'h00, 8'h00, 0, 1, 1, 1, 0, 1, 32'h17161514, 32'hA7A6A5A4));
    tbl.push_back(v(0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 0, '0, '0));

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_s_ready", 32'(s_ready), 32'd0);
    chk("reset_m_valid", 32'(m_valid), 32'd0);
    chk("reset_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].sv, tbl[i].re, tbl[i].im, tbl[i].sl, tbl[i].mr);
      chk($sformatf("row%0d_s_ready", i), 32'(s_ready), 32'(tbl[i].e_sr));
      chk($sformatf("row%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].e_mv));
      chk($sformatf("row%0d_frame_err", i), 32'(frame_err), 32'(tbl[i].e_fe));
      if (tbl[i].cd) begin
        chk($sformatf("row%0d_xn_real", i), xn_real, tbl[i].e_re);
        chk($sformatf("row%0d_xn_imag", i), xn_imag, tbl[i].e_im);
      end
    end

    // Reset after three accepted samples drops the partial frame silently
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 8'(8'h55 + i), 8'(8'h65 + i), 1'b0, 1'b1);
    end
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_s_ready", 32'(s_ready), 32'd1);
    chk("postrst_m_valid", 32'(m_valid), 32'd0);
    chk("postrst_frame_err", 32'(frame_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      drive(1'b1, 8'(8'h61 + i), 8'(8'h71 + i), (i == 3), 1'b1);
    end
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    chk("postrst_frame_valid", 32'(m_valid), 32'd1);
    chk("postrst_frame_err2", 32'(frame_err), 32'd0);
    chk("postrst_xn_real", xn_real, 32'h64636261);
    chk("postrst_xn_imag", xn_imag, 32'h74737271);

    // Sustained streaming: 16 samples, one per cycle, four frames out
    frames = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c < 16) drive(1'b1, 8'(8'h40 + c), 8'(8'hC0 + c), ((c % 4) == 3), 1'b1);
      else        drive(1'b0, '0, '0, 1'b0, 1'b1);
      if (c > 0) chk($sformatf("stream%0d_s_ready", c), 32'(s_ready), 32'd1);
      if (m_valid) begin
        for (int k = 0; k < 4; k++) begin
          exp_re[8*k +: 8] = 8'(8'h40 + 4*frames + k);
          exp_im[8*k +: 8] = 8'(8'hC0 + 4*frames + k);
        end
        chk($sformatf("stream_f%0d_cycle", frames), 32'(c), 32'(4 * (frames + 1)));
        chk($sformatf("stream_f%0d_xn_real", frames), xn_real, exp_re);
        chk($sformatf("stream_f%0d_xn_imag", frames), xn_imag, exp_im);
        frames++;
      end
      chk($sformatf("stream%0d_frame_err", c), 32'(frame_err), 32'd0);
    end
    chk("stream_frame_count", 32'(frames), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
